// File: rtl/fifo_umbrales.sv
// Synchronous FIFO for one virtual channel, with occupancy flags and
// programmable low/high thresholds for flow control.
module fifo_umbrales #(
    parameter int unsigned DATA_WIDTH   = 6,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned UMBRALES_L_H = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    pop,
    input  logic [UMBRALES_L_H-1:0] umbral_L,
    input  logic [UMBRALES_L_H-1:0] umbral_H,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic                    error
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_error;

    logic w_pop_ok;
    logic w_push_ok;
    logic w_overflow;
    logic w_underflow;

    // Flags derive only from the registered count and the live thresholds.
    assign empty        = (r_count == CW'(0));
    assign full         = (r_count == CW'(DEPTH));
    assign almost_empty = (UMBRALES_L_H'(r_count) <= umbral_L);
    assign almost_full  = (UMBRALES_L_H'(r_count) >= umbral_H);

    assign w_pop_ok    = pop && !empty;
    assign w_push_ok   = push && (!full || w_pop_ok);
    assign w_overflow  = push && !w_push_ok;
    assign w_underflow = pop && empty;

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign count     = r_count;
    assign error     = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_error     <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= data_in;
                r_wr_ptr        <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            // Read sees the pre-edge array contents, so push+pop when full is read-before-write.
            r_valid_out <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_umbrales.md
# fifo_umbrales

Synchronous FIFO with programmable occupancy thresholds, one instance per virtual channel of the PCIe v2 datapath. It produces the `empty` flag consumed by the link-state FSM (`empty_fifo_0..7`) and compares occupancy against the `umbral_L`/`umbral_H` values that the FSM latches during INIT, producing `almost_empty`/`almost_full` for flow control. Push side faces the upstream demux or arbiter. Pop side faces the downstream arbiter.

## Interface
- `DATA_WIDTH`, 6, width of each stored word
- `ADDR_WIDTH`, 3, log2 of depth (depth = 8)
- `UMBRALES_L_H`, 8, width of threshold inputs
- `clk` in 1 — single clock, all state updates on rising edge
- `reset` in 1 — synchronous, active-high
- `push` in 1 — write `data_in` this cycle
- `data_in` in DATA_WIDTH — write data
- `pop` in 1 — read one word this cycle
- `umbral_L` in UMBRALES_L_H — low threshold (from FSM `umbral_L_out`)
- `umbral_H` in UMBRALES_L_H — high threshold (from FSM `umbral_H_out`)
- `data_out` out DATA_WIDTH — registered read data
- `valid_out` out 1 — `data_out` holds a word popped the previous cycle
- `count` out ADDR_WIDTH+1 — current occupancy, 0..2^ADDR_WIDTH
- `empty` out 1 — count == 0
- `full` out 1 — count == 2^ADDR_WIDTH
- `almost_empty` out 1 — count <= umbral_L
- `almost_full` out 1 — count >= umbral_H
- `error` out 1 — sticky overflow/underflow indicator

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH register array. Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_WIDTH bits wide and wrap naturally from 2^ADDR_WIDTH−1 to 0. Separate `count` register.
- Push accepted iff `push && (!full || pop_accepted)`. It writes `mem[wr_ptr]` and increments `wr_ptr`.
- Pop accepted iff `pop && !empty`. It registers `mem[rd_ptr]` into `data_out`, sets `valid_out`=1 and increments `rd_ptr`. A cycle with no accepted pop sets `valid_out`=0. `data_out` holds its last value.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push+pop while full: both accepted. The read returns the old word at `rd_ptr` (read-before-write), and count stays at full.
- Simultaneous push+pop while empty: push accepted and pop rejected. `error` is set. Count becomes 1.
- Overflow: push while full without pop. The word is dropped, pointers are unchanged and `error` is set.
- Underflow: pop while empty. Nothing is read, `valid_out`=0 next cycle and `error` is set.
- `error` stays at 1 until `reset`.
- Threshold compare: `count` is zero-extended to UMBRALES_L_H bits, and the comparison is unsigned. `umbral_H`=0 forces `almost_full`=1. `umbral_L` ≥ depth forces `almost_empty`=1. Thresholds are not latched. Any change takes effect in the same cycle.
- `empty`, `full`, `almost_empty` and `almost_full` are combinational functions of the registered `count` and the threshold inputs. No other logic feeds them.

## Timing
- Reset, sampled at the edge: pointers=0, count=0, every `mem` entry=0, `data_out`=0, `valid_out`=0, `error`=0. This gives `empty`=1, `full`=0, `almost_empty`=1, and `almost_full`=(umbral_H==0).
- Reset has priority over push/pop in the same cycle. Mid-operation reset discards all stored data.
- Flags reflect accepted operations one cycle after the edge that sampled them. With a push at edge N, `empty` falls after edge N.
- Pop latency: pop sampled at edge N gives `data_out`/`valid_out` valid after edge N, for one cycle.
- Back-to-back pops every cycle give one word per cycle. Throughput is 1 push + 1 pop per cycle.
- No combinational path from `push`/`pop` to any output.

## Test plan
- Reset then idle with umbral_L=1 and umbral_H=6 -> `empty`=1, `almost_empty`=1, `almost_full`=0, `full`=0, `count`=0, `error`=0.
- Push 0x01..0x08 on consecutive cycles with thresholds L=1, H=6 -> `almost_empty` drops once count=2, `almost_full` rises once count=6, `full`=1 at count=8, and `error` stays 0.
- From full, push 0x3F without pop -> word dropped, `count`=8, `error`=1. Then pop 8 times -> `data_out` sequence is 0x01..0x08 with `valid_out`=1 each cycle, ending with `empty`=1.
- Pop on empty -> `valid_out`=0, `count`=0, `error`=1. Reset -> `error`=0.
- Fill to 8, then push+pop every cycle for 16 cycles with incrementing data -> `count` stays 8, outputs are in order, pointers wrap twice, and `error`=0.
- Fill to 4, change umbral_H from 6 to 4 -> `almost_full` rises in the same cycle with no push. Assert `reset` with push=1 -> next cycle `count`=0 and `empty`=1.
